lut_sweep_checker: RTL and testbench
====================================

Name: lut_sweep_checker

Overview:
- Sequential self-check stage that sits directly upstream of the combinational function LUT block and consumes its outputs.
- On start, it sweeps every W_X-bit x code and drives the factorial, quadratic and inverse-quadratic inputs of the LUT block.
- It registers the results and checks LUT against function, factorial against a running product, and the inverse round-trip.
- It reports per-category failure counts and the first failing x; used for power-on/BIST of the LUT contents.

Parameters:
- W_X, 4, x code width; must match the LUT block.
- W_Y, 8, y code width; must match the LUT block.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle sweep request; ignored while busy
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the sweep completes
- xf  out  W_X  to LUT factorial input
- xq  out  W_X  to LUT quadratic input
- yiq  out  W_Y  to LUT inverse-quadratic input
- yf  in  W_Y  from LUT, factorial result
- yq_lut  in  W_Y  from LUT, quadratic table result
- yq_fun  in  W_Y  from LUT, quadratic function result
- xiq  in  W_X  from LUT, inverse-quadratic result
- fact_fail_cnt  out  W_X+1  factorial mismatches
- quad_fail_cnt  out  W_X+1  yq_lut != yq_fun mismatches
- rt_fail_cnt  out  W_X+1  round-trip failures
- first_fail_x  out  W_X  x code of the first failure of any kind
- first_fail_valid  out  1  first_fail_x holds a real value

Behaviour:
- Reset: the async reset forces all outputs and internal state to 0 and the FSM to IDLE.
  - It acts immediately, including mid-sweep.
  - No done pulse occurs and counters are not preserved.
- LUT block is combinational. Drive registers are updated at an edge; results are sampled at the next edge.
- FSM states and transitions:
  - IDLE: start=1 → PH_Q with x=0, fact_ref=1, all counters, first_fail_x and first_fail_valid cleared.
  - PH_Q (xq=x, xf=x when x MSB=0, else xf=0): at the edge, capture y1=yq_fun.
    - When x MSB=0: compare yq_lut vs yq_fun and yf vs fact_ref. A mismatch increments the respective counter.
    - Negative x codes skip both checks because the LUT index is treated as out of range.
    - Go to PH_I.
  - PH_I (yiq=y1): capture xr=xiq, go to PH_R.
  - PH_R (xq=xr): compare yq_fun vs y1; a mismatch increments rt_fail_cnt.
    - The round trip compares y rather than x, because duplicate roots are legal (e.g. y=-26 has roots x=-8 and x=-2).
    - Update fact_ref = (fact_ref * (x+1)) mod 2^W_Y, using the unsigned x code.
    - If x = 2^W_X-1 → DONE; else increment x and go to PH_Q.
  - DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- busy is high in PH_Q/PH_I/PH_R. Total sweep is 3*2^W_X cycles (48 at defaults) from start to the done pulse.
- yiq, xq and xf are held at 0 in IDLE/DONE.
- first_fail tracking: on the first failure of any category, latch x and set first_fail_valid. Later failures do not overwrite it.
  - Multiple failures in the same PH_Q count separately in their own counters.
- Counters cannot overflow; W_X+1 bits hold 2^W_X.
- Results hold until the next accepted start.
- start asserted in DONE is ignored; start while busy is ignored.
- All comparisons are on raw W_Y-bit patterns, so signed and unsigned interpretation is irrelevant.
- Factorial wrap-around is required: fact_ref follows the same truncation as the LUT block (6! → 0xD0, 7! → 0xB0).

Test Plan:
- Reset, then start with a correct LUT (A=1, B=10, C=-10) → busy for 48 cycles, then one done pulse.
  - Required: all three counters 0, first_fail_valid=0.
- Same sweep, probing mid-sweep → at x=3 PH_Q, yq_fun=29 and yiq=29 in PH_I; at x=5, yf=0x78 (120); at x=6, yf=0xD0.
  - Required: no failures counted.
- Bench LUT model with lut_quadratic[2] corrupted to 0 → quad_fail_cnt=1, first_fail_x=2, first_fail_valid=1.
  - Required: the round trip still passes (rt_fail_cnt=0), since it uses yq_fun.
- Bench model with inverse entry for y=-19 forced to x=0 → rt_fail_cnt=1, first_fail_x=15 (code for -1).
  - With the factorial entry for x=4 also corrupted, first_fail_x=4 and fact_fail_cnt=1.
- rst_n pulsed low at cycle 20 of a sweep → all outputs 0 asynchronously with no done pulse; a new start runs a full 48-cycle sweep.
- start held high continuously → pulses are ignored during busy and DONE; a new sweep begins only from IDLE, the cycle after done.

Source files
------------

// File: rtl/lut_sweep_checker.sv
// Power-on self-check for the function LUT block: sweeps every x code, checks
// the quadratic table, the factorial table and the inverse-quadratic round trip.
module lut_sweep_checker #(
  parameter int W_X = 4,
  parameter int W_Y = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [W_X-1:0] xf,
  output logic [W_X-1:0] xq,
  output logic [W_Y-1:0] yiq,
  input  logic [W_Y-1:0] yf,
  input  logic [W_Y-1:0] yq_lut,
  input  logic [W_Y-1:0] yq_fun,
  input  logic [W_X-1:0] xiq,
  output logic [W_X:0]   fact_fail_cnt,
  output logic [W_X:0]   quad_fail_cnt,
  output logic [W_X:0]   rt_fail_cnt,
  output logic [W_X-1:0] first_fail_x,
  output logic           first_fail_valid
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // PH_Q  | xq/xf = x; check quadratic table and factorial (x >= 0 only)
  // PH_I  | yiq = y1; capture inverse root into xq
  // PH_R  | xq = root; round-trip y check, advance factorial and x
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, PH_Q, PH_I, PH_R, DONE} state_t;

  state_t         state;
  logic [W_X-1:0] x;
  logic [W_X-1:0] x_nxt;
  logic [W_X:0]   xp1;
  logic [W_Y-1:0] y1;
  logic [W_Y-1:0] fact_ref;
  logic           q_fail, f_fail, r_fail;

  always_comb begin
    xp1    = {1'b0, x} + (W_X+1)'(1);
    x_nxt  = x + W_X'(1);
    q_fail = (state == PH_Q) && !x[W_X-1] && (yq_lut != yq_fun);
    f_fail = (state == PH_Q) && !x[W_X-1] && (yf != fact_ref);
    r_fail = (state == PH_R) && (yq_fun != y1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      xf               <= '0;
      xq               <= '0;
      yiq              <= '0;
      x                <= '0;
      y1               <= '0;
      fact_ref         <= '0;
      fact_fail_cnt    <= '0;
      quad_fail_cnt    <= '0;
      rt_fail_cnt      <= '0;
      first_fail_x     <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state            <= PH_Q;
            busy             <= 1'b1;
            x                <= '0;
            xq               <= '0;
            xf               <= '0;
            fact_ref         <= W_Y'(1);
            fact_fail_cnt    <= '0;
            quad_fail_cnt    <= '0;
            rt_fail_cnt      <= '0;
            first_fail_x     <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        PH_Q: begin
          y1    <= yq_fun;
          yiq   <= yq_fun;
          xq    <= '0;
          xf    <= '0;
          state <= PH_I;
          if (q_fail) quad_fail_cnt <= quad_fail_cnt + (W_X+1)'(1);
          if (f_fail) fact_fail_cnt <= fact_fail_cnt + (W_X+1)'(1);
        end
        PH_I: begin
          xq    <= xiq;
          yiq   <= '0;
          state <= PH_R;
        end
        PH_R: begin
          if (r_fail) rt_fail_cnt <= rt_fail_cnt + (W_X+1)'(1);
          fact_ref <= fact_ref * W_Y'(xp1);
          if (x == '1) begin
            xq    <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x     <= x_nxt;
            xq    <= x_nxt;
            xf    <= x_nxt[W_X-1] ? '0 : x_nxt;
            state <= PH_Q;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Only the first failure of any category is recorded.
      if ((q_fail || f_fail || r_fail) && !first_fail_valid) begin
        first_fail_x     <= x;
        first_fail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench for lut_sweep_checker with a behavioural LUT model
// (y = x^2 + 10x - 10, factorial mod 256) that can be selectively corrupted.
module tb_lut_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] xf, xq, xiq, first_fail_x;
  logic [7:0] yiq, yf, yq_lut, yq_fun;
  logic [4:0] fact_fail_cnt, quad_fail_cnt, rt_fail_cnt;
  logic       first_fail_valid;

  bit quad_bad2 = 0;
  bit inv_bad   = 0;
  bit fact_bad4 = 0;

  int total = 0;
  int bad   = 0;

  lut_sweep_checker #(.W_X(4), .W_Y(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .xf(xf), .xq(xq), .yiq(yiq), .yf(yf), .yq_lut(yq_lut), .yq_fun(yq_fun),
    .xiq(xiq), .fact_fail_cnt(fact_fail_cnt), .quad_fail_cnt(quad_fail_cnt),
    .rt_fail_cnt(rt_fail_cnt), .first_fail_x(first_fail_x),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] quad(input logic [3:0] xc);
    int xi;
    int y;
    xi = int'($signed(xc));
    y  = xi * xi + 10 * xi - 10;
    return y[7:0];
  endfunction

  function automatic logic [7:0] fact(input logic [3:0] xc);
    int p;
    p = 1;
    for (int i = 2; i <= int'(xc); i++) p = p * i;
    return p[7:0];
  endfunction

  always_comb begin
    logic found;
    found  = 1'b0;
    xiq    = '0;
    yq_fun = quad(xq);
    yq_lut = (quad_bad2 && xq == 4'd2) ? 8'h00 : quad(xq);
    yf     = (xf[3]) ? 8'h00 : fact(xf);
    if (fact_bad4 && xf == 4'd4) yf = fact(xf) ^ 8'hFF;
    for (int c = 0; c < 16; c++) begin
      if (!found && quad(4'(c)) == yiq) begin
        xiq   = 4'(c);
        found = 1'b1;
      end
    end
    if (inv_bad && yiq == 8'hED) xiq = 4'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; pulses start and runs until done (bounded).
  task automatic run_sweep(input bit probe, output int n, output int busy_n);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = 0;
    busy_n = 0;
    check("busy_after_start", busy, 1);
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (probe && n == 9)  begin check("x3_xq", xq, 3); check("x3_yq_fun", yq_fun, 29); end
      if (probe && n == 10) check("x3_yiq", yiq, 29);
      if (probe && n == 15) begin check("x5_xf", xf, 5); check("x5_yf", yf, 8'h78); end
      if (probe && n == 18) check("x6_yf", yf, 8'hD0);
      if (probe && n == 21) check("x7_yf", yf, 8'hB0);
      if (probe && n == 24) check("x8_xf_zero", xf, 0);
      @(posedge clk); #1;
      n++;
    end
    check("sweep_len", n, 48);
    check("busy_cycles", busy_n, 48);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_results(input string tag, input int f, input int q, input int r,
                               input int fx, input int fv);
    check({tag, "_fact"}, fact_fail_cnt, f);
    check({tag, "_quad"}, quad_fail_cnt, q);
    check({tag, "_rt"}, rt_fail_cnt, r);
    check({tag, "_ffx"}, first_fail_x, fx);
    check({tag, "_ffv"}, first_fail_valid, fv);
  endtask

  initial begin
    int n, bn, dcount;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xq", xq, 0);
    check("rst_yiq", yiq, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean sweep with mid-sweep probes
    run_sweep(1'b1, n, bn);
    check_results("clean", 0, 0, 0, 0, 0);

    quad_bad2 = 1;
    run_sweep(1'b0, n, bn);
    check_results("quad2", 0, 1, 0, 2, 1);
    quad_bad2 = 0;

    inv_bad = 1;
    run_sweep(1'b0, n, bn);
    check_results("inv", 0, 0, 1, 15, 1);

    fact_bad4 = 1;
    run_sweep(1'b0, n, bn);
    check_results("inv_fact4", 1, 0, 1, 4, 1);
    inv_bad   = 0;
    fact_bad4 = 0;

    // Asynchronous reset in the middle of a sweep that already has a failure
    quad_bad2 = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_xf", xf, 0);
    check("mid_rst_xq", xq, 0);
    check("mid_rst_yiq", yiq, 0);
    check_results("mid_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quad_bad2 = 0;
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("no_done_after_rst", dcount, 0);
    run_sweep(1'b0, n, bn);
    check_results("post_rst", 0, 0, 0, 0, 0);

    // start held high throughout
    start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_sweep_len", n, 48);
    @(posedge clk); #1;
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    @(posedge clk); #1;
    check("held_restart_busy", busy, 1);
    check("held_restart_xq", xq, 0);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("final_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
